sha1_msg_padder: RTL and testbench

Message fetch and padding stage for the SHA-1 datapath. It reads the message from the dual-port SRAM (port A), applies SHA-1 padding (0x80 marker, zero fill, 64-bit big-endian bit length), and streams 32-bit big-endian words, 16 per 512-bit block, to the downstream compression core through a valid/ready handshake. A 2-entry output FIFO with credit-based prefetch sustains one word per cycle while the core accepts words.

---
 rtl/sha1_msg_padder.sv | 250 +++++++++++++++++++++++++
 tb/tb_sha1_msg_padder.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha1_msg_padder.sv
// SHA-1 message fetch and padding stage.
// Reads message words from SRAM port A, applies SHA-1 padding (0x80 marker,
// zero fill, 64-bit big-endian bit length) and streams 32-bit words, 16 per
// 512-bit block, through a 2-entry FIFO with credit-based prefetch.
module sha1_msg_padder (
  input  logic        clk,
  input  logic        nreset,
  input  logic        start,
  input  logic [31:0] message_addr,
  input  logic [31:0] message_size,
  output logic        port_A_clk,
  output logic [15:0] port_A_addr,
  output logic        port_A_we,
  input  logic [31:0] port_A_data_out,
  output logic        busy,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [31:0] word_data,
  output logic [3:0]  word_idx,
  output logic        block_last,
  output logic        msg_last,
  output logic        done
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        blast;
    logic        mlast;
  } entry_t;

  // FSM and latched message parameters
  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_base;
  logic [31:0] r_size;
  logic [31:0] r_total;
  logic [31:0] r_w;

  // One-cycle in-flight stage (SRAM read latency, also taken by pad slots)
  logic        r_if_valid;
  logic        r_if_read;
  logic [1:0]  r_if_nbytes;
  logic [31:0] r_if_const;
  logic [3:0]  r_if_idx;
  logic        r_if_blast;
  logic        r_if_mlast;

  // Output FIFO: head entry drives the outputs, tail holds the second word
  entry_t      r_head;
  entry_t      r_tail;
  logic [1:0]  r_occ;
  logic        r_done;

  logic        w_pop;
  logic        w_push;
  logic        w_issue;
  logic [2:0]  w_used;
  logic [31:0] w_total_in;
  logic [33:0] w_off;
  logic [33:0] w_size34;
  logic        w_is_data;
  logic        w_is_part;
  logic        w_is_mark;
  logic        w_is_last;
  logic        w_is_len_hi;
  logic        w_read;
  logic [31:0] w_const;
  logic [31:0] w_in_data;
  entry_t      w_in;
  logic        w_unused_addr_bits;

  assign port_A_clk = clk;
  assign port_A_we  = 1'b0;

  assign word_valid = (r_occ != 2'd0);
  assign word_data  = r_head.data;
  assign word_idx   = r_head.idx;
  assign block_last = r_head.blast;
  assign msg_last   = r_head.mlast;
  assign done       = r_done;
  assign busy       = (r_state != S_IDLE);

  // Only the low 16 address bits reach the SRAM.
  assign w_unused_addr_bits = ^message_addr[31:16];

  assign w_pop  = word_valid & word_ready;
  assign w_push = r_if_valid;

  // Slots already committed after this cycle's pop; a new slot may issue
  // only while fewer than two words are held or in flight.
  assign w_used = {1'b0, r_occ} + {2'b00, r_if_valid} - {2'b00, w_pop};

  // Total padded word count T = 16 * (((S + 8) >> 6) + 1).
  assign w_total_in = (((message_size + 32'd8) >> 6) + 32'd1) << 4;

  // Classify slot r_w by its byte offset against the message size.
  assign w_off       = {r_w, 2'b00};
  assign w_size34    = {2'b00, r_size};
  assign w_is_data   = (w_off + 34'd4) <= w_size34;
  assign w_is_part   = (w_off < w_size34) && !w_is_data;
  assign w_is_mark   = (w_off == w_size34);
  assign w_is_last   = (r_w == r_total - 32'd1);
  assign w_is_len_hi = (r_w == r_total - 32'd2);
  assign w_read      = w_is_data | w_is_part;

  // Constant word for slots that need no memory read
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    w_const = 32'h0;
    if (w_is_mark)        w_const = 32'h8000_0000;
    else if (w_is_len_hi) w_const = {29'b0, r_size[31:29]};
    else if (w_is_last)   w_const = {r_size[28:0], 3'b000};
  end

  // Next-state and issue decision
  always_comb begin
    w_state_next = r_state;
    w_issue      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_RUN;
      end
      S_RUN: begin
        if (w_used < 3'd2) begin
          w_issue = 1'b1;
          if (w_is_last) w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_pop && r_head.mlast) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge nreset) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (nreset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Latch message parameters on start and advance the slot counter on issue
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      r_base  <= 16'h0;
      r_size  <= 32'h0;
      r_total <= 32'h0;
      r_w     <= 32'h0;
    end else if (r_state == S_IDLE && start) begin
      r_base  <= message_addr[15:0];
      r_size  <= message_size;
      r_total <= w_total_in;
      r_w     <= 32'h0;
    end else if (w_issue) begin
      r_w <= r_w + 32'd1;
    end
  end

  // Issue stage: register the SRAM address on reads and the slot descriptor
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) begin
      port_A_addr <= 16'h0;
      r_if_valid  <= 1'b0;
      r_if_read   <= 1'b0;
      r_if_nbytes <= 2'd0;
      r_if_const  <= 32'h0;
      r_if_idx    <= 4'd0;
      r_if_blast  <= 1'b0;
      r_if_mlast  <= 1'b0;
    end else begin
      r_if_valid <= w_issue;
      if (w_issue) begin
        r_if_read   <= w_read;
        r_if_nbytes <= w_is_part ? r_size[1:0] : 2'd0;
        r_if_const  <= w_const;
        r_if_idx    <= r_w[3:0];
        r_if_blast  <= (r_w[3:0] == 4'd15);
        r_if_mlast  <= w_is_last;
        if (w_read) port_A_addr <= r_base + {r_w[13:0], 2'b00};
      end
    end
  end

  // Build the word entering the FIFO from SRAM data or the slot constant
  always_comb begin
    w_in_data = r_if_const;
    if (r_if_read) begin
      unique case (r_if_nbytes)
        2'd1:    w_in_data = {port_A_data_out[31:24], 8'h80, 16'h0};
        2'd2:    w_in_data = {port_A_data_out[31:16], 8'h80, 8'h0};
        2'd3:    w_in_data = {port_A_data_out[31:8], 8'h80};
        default: w_in_data = port_A_data_out;
      endcase
    end
  end

  assign w_in = '{data: w_in_data, idx: r_if_idx, blast: r_if_blast, mlast: r_if_mlast};

  // Two-entry FIFO; push and pop together keep occupancy unchanged
  always_ff @(posedge clk or posedge nreset) begin
    // NOTE: FIFO storage is reset too, because the head entry drives the outputs directly.
    if (nreset) begin
      r_occ  <= 2'd0;
      r_head <= '0;
      r_tail <= '0;
    end else begin
      unique case (r_occ)
        2'd0: begin
          if (w_push) begin
            r_head <= w_in;
            r_occ  <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_pop) begin
            r_head <= w_in;
          end else if (w_push) begin
            r_tail <= w_in;
            r_occ  <= 2'd2;
          end else if (w_pop) begin
            r_occ <= 2'd0;
          end
        end
        2'd2: begin
          if (w_pop) begin
            r_head <= r_tail;
            if (w_push) r_tail <= w_in;
            else        r_occ  <= 2'd1;
          end
        end
        default: r_occ <= 2'd0;
      endcase
    end
  end

  // Completion pulse after the final word is accepted
  always_ff @(posedge clk or posedge nreset) begin
    if (nreset) r_done <= 1'b0;
    else        r_done <= w_pop & r_head.mlast;
  end

endmodule

// File: tb/tb_sha1_msg_padder.sv
// Self-checking bench for sha1_msg_padder: byte-level SHA-1 padding model
// feeding a scoreboard queue, and a monitor that pops on every accepted word.
module tb_sha1_msg_padder;

  logic        clk;
  logic        nreset;
  logic        start;
  logic [31:0] message_addr;
  logic [31:0] message_size;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_out;
  logic        busy;
  logic        word_valid;
  logic        word_ready;
  logic [31:0] word_data;
  logic [3:0]  word_idx;
  logic        block_last;
  logic        msg_last;
  logic        done;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        blast;
    logic        mlast;
  } exp_t;

  exp_t        sb_q[$];
  logic [31:0] mem [0:16383];
  int          n_total;
  int          n_bad;
  int          n_acc;
  int          cyc;

  sha1_msg_padder dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_out (port_A_data_out),
    .busy            (busy),
    .word_valid      (word_valid),
    .word_ready      (word_ready),
    .word_data       (word_data),
    .word_idx        (word_idx),
    .block_last      (block_last),
    .msg_last        (msg_last),
    .done            (done)
  );

  // SRAM: data for the registered address is visible one cycle later at capture.
  assign port_A_data_out = mem[port_A_addr[15:2]];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk);
      cyc++;
    end
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] msg_byte(input logic [15:0] base, input int i);
    logic [15:0] a;
    logic [31:0] w;
    a = base + 16'(i);
    w = mem[a[15:2]];
    return w[31 - 8 * int'(a[1:0]) -: 8];
  endfunction

  // Reference: build the padded byte stream, then cut it into big-endian words.
  task automatic push_expected(input logic [15:0] base, input int size, output int total);
    int          nb;
    int          idx;
    logic [7:0]  b;
    logic [63:0] len64;
    logic [31:0] word;
    exp_t        e;
    nb    = ((size + 9 + 63) / 64) * 64;
    total = nb / 4;
    len64 = 64'(size) * 64'd8;
    for (int w = 0; w < total; w++) begin
      word = 32'h0;
      for (int j = 0; j < 4; j++) begin
        idx = 4 * w + j;
        if (idx < size)          b = msg_byte(base, idx);
        else if (idx == size)    b = 8'h80;
        else if (idx >= nb - 8)  b = len64[8 * (nb - 1 - idx) +: 8];
        else                     b = 8'h00;
        word = {word[23:0], b};
      end
      e.data  = word;
      e.idx   = 4'(w % 16);
      e.blast = ((w % 16) == 15);
      e.mlast = (w == total - 1);
      sb_q.push_back(e);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"},  64'(port_A_addr), 64'h0);
    check({tag, "_we"},    64'(port_A_we),   64'h0);
    check({tag, "_busy"},  64'(busy),        64'h0);
    check({tag, "_valid"}, 64'(word_valid),  64'h0);
    check({tag, "_data"},  64'(word_data),   64'h0);
    check({tag, "_idx"},   64'(word_idx),    64'h0);
    check({tag, "_blast"}, 64'(block_last),  64'h0);
    check({tag, "_mlast"}, 64'(msg_last),    64'h0);
    check({tag, "_done"},  64'(done),        64'h0);
  endtask

  // Monitor: compare each accepted word against the scoreboard head.
  initial begin : monitor
    logic        exp_done;
    logic        hold;
    logic [31:0] hold_data;
    exp_t        e;
    exp_done = 1'b0;
    hold     = 1'b0;
    hold_data = 32'h0;
    forever begin
      @(negedge clk);
      if (nreset) begin
        exp_done = 1'b0;
        hold     = 1'b0;
      end else begin
        check("done", 64'(done), 64'(exp_done));
        if (hold) begin
          check("stall_valid", 64'(word_valid), 64'h1);
          check("stall_data",  64'(word_data),  64'(hold_data));
        end
        exp_done = 1'b0;
        if (word_valid && word_ready) begin
          if (sb_q.size() == 0) begin
            n_total++;
            n_bad++;
            $display("FAIL extra_word: got=%0h expected=none", word_data);
          end else begin
            e = sb_q.pop_front();
            check("word_data",  64'(word_data),  64'(e.data));
            check("word_idx",   64'(word_idx),   64'(e.idx));
            check("block_last", 64'(block_last), 64'(e.blast));
            check("msg_last",   64'(msg_last),   64'(e.mlast));
            exp_done = e.mlast;
          end
          n_acc++;
        end
        hold      = word_valid && !word_ready;
        hold_data = word_data;
      end
    end
  end

  // mode: 0 ready high, 1 random ready, 2 five-cycle stall, 3 start pulse while busy
  task automatic run_msg(input logic [15:0] base, input int size, input int mode,
                         input int abort_at, input bit timing);
    int          total;
    int          t0;
    int          budget;
    bit          got_done;
    logic [15:0] frozen;
    push_expected(base, size, total);
    n_acc    = 0;
    got_done = 1'b0;
    frozen   = 16'h0;
    budget   = total * 20 + 100;
    @(posedge clk);
    #1;
    start        = 1'b1;
    message_addr = {16'($urandom), base};
    message_size = 32'(size);
    word_ready   = 1'b1;
    @(posedge clk);
    #1;
    t0    = cyc;
    start = 1'b0;
    for (int c = 0; c < budget; c++) begin
      @(posedge clk);
      #1;
      if (c == 0) check("busy_after_start", 64'(busy), 64'h1);
      if (timing && c == 0) begin
        check("first_addr",  64'(port_A_addr), 64'(base));
        check("first_valid", 64'(word_valid),  64'h0);
      end
      if (timing && c == 1) check("second_valid", 64'(word_valid), 64'h1);
      if (mode == 2 && c == 9) frozen = port_A_addr;
      if (mode == 2 && c >= 10 && c <= 12) check("addr_frozen", 64'(port_A_addr), 64'(frozen));
      if (mode == 3 && c == 4) begin
        start        = 1'b1;
        message_addr = $urandom;
        message_size = 32'($urandom_range(0, 500));
      end
      if (mode == 3 && c == 5) start = 1'b0;
      if (abort_at > 0 && n_acc >= abort_at) begin
        nreset     = 1'b1;
        start      = 1'b0;
        word_ready = 1'b0;
        sb_q.delete();
        #1;
        check_reset_outputs("abort");
        @(posedge clk);
        #1;
        nreset = 1'b0;
        repeat (6) @(posedge clk);
        return;
      end
      if (done) begin
        got_done = 1'b1;
        if (mode == 0 || mode == 3) check("latency", 64'(cyc - t0), 64'(total + 2));
        check("busy_after_done", 64'(busy), 64'h0);
        break;
      end
      if (mode == 1)                      word_ready = ($urandom_range(0, 99) < 70);
      else if (mode == 2 && c >= 8 && c <= 12) word_ready = 1'b0;
      else                                word_ready = 1'b1;
    end
    if (!got_done) begin
      n_total++;
      n_bad++;
      $display("FAIL timeout: got=no_done expected=done size=%0d", size);
    end
    check("scoreboard_empty", 64'(sb_q.size()), 64'h0);
    word_ready = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  initial begin : stimulus
    logic [15:0] base;
    n_total      = 0;
    n_bad        = 0;
    n_acc        = 0;
    nreset       = 1'b1;
    start        = 1'b0;
    word_ready   = 1'b0;
    message_addr = 32'h0;
    message_size = 32'h0;
    for (int i = 0; i < 16384; i++) mem[i] = $urandom;

    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    nreset = 1'b0;

    run_msg(16'h0000, 0, 0, 0, 1'b0);
    mem[16'h0040 >> 2] = 32'h6162_6300;
    run_msg(16'h0040, 3, 0, 0, 1'b0);
    run_msg(16'h0100, 56, 0, 0, 1'b1);
    run_msg(16'h0200, 64, 2, 0, 1'b0);
    run_msg(16'h0300, 100, 0, 7, 1'b0);
    run_msg(16'h0300, 100, 0, 0, 1'b1);
    run_msg(16'h0400, 20, 3, 0, 1'b0);
    run_msg(16'hFFF0, 40, 1, 0, 1'b0);
    for (int k = 0; k < 6; k++) begin
      base = 16'($urandom_range(0, 16383) << 2);
      run_msg(base, $urandom_range(0, 200), 1, 0, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
